mips_fetch_sequencer: RTL and testbench
=======================================

Name: mips_fetch_sequencer

Overview:
- Program-counter and next-address sequencer for the single-cycle MIPS core.
- Drives the core's 8-bit instruction address (ReadAddr) and consumes the core's control-flow outputs (SEImm, JumpValue, Zero, Branch, Jump) to select the next fetch address each clock.
- Also owns the halt and fault supervision and the retirement/redirect counters used by the bench and debug.

Parameters:
- ADDR_W, 8, instruction address width; matches the core's ReadAddr width.
- RESET_PC, 8'h00, PC value loaded on reset.
- IMEM_BYTES, 128, instruction memory size in bytes; a PC at or above this value is a fault.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  when 1, hold the PC and counters; the current instruction is not retired.
- SEImm  in  32  sign-extended branch immediate from the core.
- JumpValue  in  26  jump field from the core.
- Zero  in  1  ALU zero flag from the core.
- Branch  in  1  branch control from the core.
- Jump  in  1  jump control from the core.
- ReadAddr  out  ADDR_W  current PC, connected to the core's ReadAddr.
- halted  out  1  program ended with a jump-to-self; sticky.
- fault  out  1  PC was misaligned or out of range; sticky.
- instr_count  out  CNT_W  retired instructions, saturating.
- redirect_count  out  CNT_W  taken branches plus jumps, saturating.

Behaviour:
- Reset (async assert, sync release):
  - ReadAddr = RESET_PC; state = RUN.
  - halted = 0, fault = 0, instr_count = 0, redirect_count = 0.
  - Reset asserted mid-operation aborts immediately with no partial update.
- ReadAddr is the PC register output directly, with no combinational path from inputs. The core therefore sees the new address one cycle after the decision.
- Address arithmetic is modulo 2^ADDR_W, and carries are discarded:
  - seq = PC + 4.
  - btgt = seq + {SEImm[ADDR_W-3:0], 2'b00}; upper SEImm bits are ignored.
  - jtgt = {JumpValue[ADDR_W-3:0], 2'b00}.
- Next-PC priority when a cycle is retired:
  1. Jump = 1 → jtgt.
  2. Branch & Zero → btgt.
  3. Otherwise → seq.
  - If Jump and Branch are both 1, Jump wins and counts as one redirect.
- FSM states: RUN, HOLD, HALTED.
- RUN:
  - stall = 1 → HOLD. PC and counters unchanged.
  - Otherwise retire:
    - PC ← next.
    - instr_count +1, saturating at all-ones.
    - redirect_count +1 (saturating) if Jump or (Branch & Zero).
  - If Jump = 1 and jtgt == PC: retire, PC unchanged, set halted, go to HALTED.
  - If the next PC has next[1:0] != 0 or next >= IMEM_BYTES: do not load it (PC holds), set fault, go to HALTED. Nothing is retired or counted in that cycle.
  - Wrap-around: seq from 8'hFC yields 8'h00, which is then checked against IMEM_BYTES. With the default IMEM_BYTES, 8'hFC is itself already a fault.
- HOLD:
  - stall = 0 → RUN, with no retirement in the transition cycle.
  - The first retirement happens on the following edge, so the stall costs exactly the stall cycles plus one.
  - The PC is held throughout.
- HALTED:
  - Absorbing state; only reset exits it. PC, counters and flags are frozen, and stall is ignored.
- halted and fault are mutually exclusive, since the first event wins.
- Combinational inputs are sampled only on the rising edge. X on the control inputs while stall = 1 must not propagate.

Test Plan:
- Reset, then 5 cycles with no branch or jump, stall = 0 → ReadAddr 00,04,08,0C,10,14; instr_count = 5; redirect_count = 0.
- PC = 08, Branch = 1, Zero = 1, SEImm = 32'hFFFFFFFD (−3) → next ReadAddr = 08+4−12 = 00. With Zero = 0 instead → 0C. redirect_count increments only in the taken case.
- PC = 10, Jump = 1, Branch = 1, Zero = 1, JumpValue = 26'h000000A, SEImm = 1 → ReadAddr = 28 (jump wins); redirect_count +1.
- PC = 24, Jump = 1, JumpValue = 26'h9 (jtgt = 24) → halted = 1 next cycle. ReadAddr stays 24 for 10 further cycles even with stall toggling; instr_count is frozen.
- PC = 7C, no branch (seq = 80 ≥ 128) → fault = 1; ReadAddr stays 7C; instr_count is not incremented for that cycle. Then assert rst_n = 0 asynchronously mid-cycle → ReadAddr = 00 and fault = 0 immediately.
- stall high for 3 cycles at PC = 0C → ReadAddr stays 0C. After release, one idle cycle, then 10; instr_count increases by exactly 1 across the 5 cycles.

Source files
------------

// File: rtl/mips_fetch_sequencer.sv
// PC and next-address sequencer for the single-cycle MIPS core, with halt/fault
// supervision and saturating retirement/redirect counters.
module mips_fetch_sequencer #(
    parameter int unsigned ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
    parameter int unsigned IMEM_BYTES = 128,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic [31:0]       SEImm,
    input  logic [25:0]       JumpValue,
    input  logic              Zero,
    input  logic              Branch,
    input  logic              Jump,
    output logic [ADDR_W-1:0] ReadAddr,
    output logic              halted,
    output logic              fault,
    output logic [CNT_W-1:0]  instr_count,
    output logic [CNT_W-1:0]  redirect_count
);

    typedef enum logic [1:0] {
        StRun,
        StHold,
        StHalted
    } state_e;

    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
    localparam logic [ADDR_W:0]   IMEM_LIMIT = IMEM_BYTES[ADDR_W:0];

    state_e            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_halted;
    logic              r_fault;
    logic [CNT_W-1:0]  r_instr_cnt;
    logic [CNT_W-1:0]  r_redir_cnt;

    state_e            w_state_nxt;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic              w_halted_nxt;
    logic              w_fault_nxt;
    logic [CNT_W-1:0]  w_instr_cnt_nxt;
    logic [CNT_W-1:0]  w_redir_cnt_nxt;

    logic [ADDR_W-1:0] w_seq;
    logic [ADDR_W-1:0] w_btgt;
    logic [ADDR_W-1:0] w_jtgt;
    logic [ADDR_W-1:0] w_next;
    logic              w_taken;
    logic              w_redirect;
    logic              w_self_jump;
    logic              w_bad_next;
    logic [CNT_W-1:0]  w_instr_inc;
    logic [CNT_W-1:0]  w_redir_inc;
    logic              w_unused_bits;

    // Only the low address bits of the immediates matter; the rest are dropped.
    assign w_unused_bits = ^{SEImm[31:ADDR_W-2], JumpValue[25:ADDR_W-2]};

    assign w_seq       = r_pc + PC_STEP;
    assign w_btgt      = w_seq + {SEImm[ADDR_W-3:0], 2'b00};
    assign w_jtgt      = {JumpValue[ADDR_W-3:0], 2'b00};
    assign w_taken     = Branch & Zero;
    assign w_redirect  = Jump | w_taken;
    assign w_next      = Jump ? w_jtgt : (w_taken ? w_btgt : w_seq);
    assign w_self_jump = Jump & (w_jtgt == r_pc);
    assign w_bad_next  = (|w_next[1:0]) | ({1'b0, w_next} >= IMEM_LIMIT);

    assign w_instr_inc = (r_instr_cnt == '1) ? r_instr_cnt : r_instr_cnt + CNT_W'(1);
    assign w_redir_inc = (r_redir_cnt == '1) ? r_redir_cnt : r_redir_cnt + CNT_W'(1);

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_halted_nxt    = r_halted;
        w_fault_nxt     = r_fault;
        w_instr_cnt_nxt = r_instr_cnt;
        w_redir_cnt_nxt = r_redir_cnt;
        unique case (r_state)
            StRun: begin
                // Control inputs are only looked at when not stalled, so X under stall is inert.
                if (stall) begin
                    w_state_nxt = StHold;
                end else if (w_self_jump) begin
                    w_instr_cnt_nxt = w_instr_inc;
                    w_redir_cnt_nxt = w_redir_inc;
                    w_halted_nxt    = 1'b1;
                    w_state_nxt     = StHalted;
                end else if (w_bad_next) begin
                    w_fault_nxt = 1'b1;
                    w_state_nxt = StHalted;
                end else begin
                    w_pc_nxt        = w_next;
                    w_instr_cnt_nxt = w_instr_inc;
                    if (w_redirect) begin
                        w_redir_cnt_nxt = w_redir_inc;
                    end
                end
            end
            StHold: begin
                if (!stall) begin
                    w_state_nxt = StRun;
                end
            end
            StHalted: begin
            end
            default: begin
                w_state_nxt = StRun;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StRun;
            r_pc        <= RESET_PC;
            r_halted    <= 1'b0;
            r_fault     <= 1'b0;
            r_instr_cnt <= '0;
            r_redir_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_halted    <= w_halted_nxt;
            r_fault     <= w_fault_nxt;
            r_instr_cnt <= w_instr_cnt_nxt;
            r_redir_cnt <= w_redir_cnt_nxt;
        end
    end

    assign ReadAddr       = r_pc;
    assign halted         = r_halted;
    assign fault          = r_fault;
    assign instr_count    = r_instr_cnt;
    assign redirect_count = r_redir_cnt;

endmodule

// File: tb/tb_mips_fetch_sequencer.sv
// Directed, table-driven bench for mips_fetch_sequencer: each vector gives the
// inputs for one clock and the registered outputs expected just after that edge.
module tb_mips_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] SEImm = '0;
    logic [25:0] JumpValue = '0;
    logic        Zero = 1'b0;
    logic        Branch = 1'b0;
    logic        Jump = 1'b0;
    logic [7:0]  ReadAddr;
    logic        halted;
    logic        fault;
    logic [15:0] instr_count;
    logic [15:0] redirect_count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        stall;
        logic        jump;
        logic        branch;
        logic        zero;
        logic [31:0] seimm;
        logic [25:0] jv;
        logic [7:0]  exp_pc;
        logic        exp_halt;
        logic        exp_fault;
        logic [15:0] exp_ic;
        logic [15:0] exp_rc;
    } vec_t;

    vec_t vec_a[$];
    vec_t vec_b[$];
    vec_t vec_c[$];

    mips_fetch_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .SEImm          (SEImm),
        .JumpValue      (JumpValue),
        .Zero           (Zero),
        .Branch         (Branch),
        .Jump           (Jump),
        .ReadAddr       (ReadAddr),
        .halted         (halted),
        .fault          (fault),
        .instr_count    (instr_count),
        .redirect_count (redirect_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] pc, input logic h,
                             input logic f, input logic [15:0] ic, input logic [15:0] rc);
        check({tag, " ReadAddr"}, 32'(ReadAddr), 32'(pc));
        check({tag, " halted"}, 32'(halted), 32'(h));
        check({tag, " fault"}, 32'(fault), 32'(f));
        check({tag, " instr_count"}, 32'(instr_count), 32'(ic));
        check({tag, " redirect_count"}, 32'(redirect_count), 32'(rc));
    endtask

    task automatic apply(input string tag, input vec_t v);
        stall     = v.stall;
        Jump      = v.jump;
        Branch    = v.branch;
        Zero      = v.zero;
        SEImm     = v.seimm;
        JumpValue = v.jv;
        @(posedge clk);
        #1;
        check_all(tag, v.exp_pc, v.exp_halt, v.exp_fault, v.exp_ic, v.exp_rc);
    endtask

    task automatic do_reset(input string tag);
        stall = 1'b0; Jump = 1'b0; Branch = 1'b0; Zero = 1'b0;
        SEImm = '0; JumpValue = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_all(tag, 8'h00, 1'b0, 1'b0, 16'd0, 16'd0);
    endtask

    initial begin
        // {stall, jump, branch, zero, seimm, jv, pc, halted, fault, ic, rc}
        vec_a.push_back('{0, 0, 0, 0, 32'h0, 26'h0, 8'h04, 0, 0, 16'd1, 16'd0});
        vec_a.push_back('{0, 0, 0, 0, 32'h0, 26'h0, 8'h08, 0, 0, 16'd2, 16'd0});
        vec_a.push_back('{0, 0, 0, 0, 32'h0, 26'h0, 8'h0C, 0, 0, 16'd3, 16'd0});
        vec_a.push_back('{0, 0, 0, 0, 32'h0, 26'h0, 8'h10, 0, 0, 16'd4, 16'd0});
        vec_a.push_back('{0, 0, 0, 0, 32'h0, 26'h0, 8'h14, 0, 0, 16'd5, 16'd0});
        vec_a.push_back('{0, 0, 1, 0, 32'hFFFFFFFD, 26'h0, 8'h18, 0, 0, 16'd6, 16'd0});
        vec_a.push_back('{0, 0, 1, 1, 32'hFFFFFFFD, 26'h0, 8'h10, 0, 0, 16'd7, 16'd1});
        vec_a.push_back('{0, 1, 0, 0, 32'h0, 26'h2, 8'h08, 0, 0, 16'd8, 16'd2});
        vec_a.push_back('{0, 0, 1, 1, 32'hFFFFFFFD, 26'h0, 8'h00, 0, 0, 16'd9, 16'd3});
        vec_a.push_back('{0, 0, 1, 0, 32'hFFFFFFFD, 26'h0, 8'h04, 0, 0, 16'd10, 16'd3});
        vec_a.push_back('{0, 1, 0, 0, 32'h0, 26'h4, 8'h10, 0, 0, 16'd11, 16'd4});
        vec_a.push_back('{0, 1, 1, 1, 32'h1, 26'hA, 8'h28, 0, 0, 16'd12, 16'd5});
        vec_a.push_back('{0, 1, 0, 0, 32'h0, 26'h3, 8'h0C, 0, 0, 16'd13, 16'd6});
        // Three stalled cycles with garbage controls, one idle cycle, then retire.
        vec_a.push_back('{1, 1, 1, 1, 32'hFFFFFFFF, 26'h3FFFFFF, 8'h0C, 0, 0, 16'd13, 16'd6});
        vec_a.push_back('{1, 1, 1, 1, 32'hFFFFFFFF, 26'h3FFFFFF, 8'h0C, 0, 0, 16'd13, 16'd6});
        vec_a.push_back('{1, 1, 1, 1, 32'hFFFFFFFF, 26'h3FFFFFF, 8'h0C, 0, 0, 16'd13, 16'd6});
        vec_a.push_back('{0, 0, 0, 0, 32'h0, 26'h0, 8'h0C, 0, 0, 16'd13, 16'd6});
        vec_a.push_back('{0, 0, 0, 0, 32'h0, 26'h0, 8'h10, 0, 0, 16'd14, 16'd6});
        // Upper SEImm bits ignored: only SEImm[5:0] = 1 contributes.
        vec_a.push_back('{0, 0, 1, 1, 32'h7FFFFF01, 26'h0, 8'h18, 0, 0, 16'd15, 16'd7});
        vec_a.push_back('{0, 1, 0, 0, 32'h0, 26'h9, 8'h24, 0, 0, 16'd16, 16'd8});
        vec_a.push_back('{0, 1, 0, 0, 32'h0, 26'h9, 8'h24, 1, 0, 16'd17, 16'd9});
        vec_a.push_back('{1, 0, 0, 0, 32'h0, 26'h0, 8'h24, 1, 0, 16'd17, 16'd9});
        vec_a.push_back('{0, 1, 0, 0, 32'h0, 26'h0, 8'h24, 1, 0, 16'd17, 16'd9});
        vec_a.push_back('{1, 0, 1, 1, 32'h4, 26'h0, 8'h24, 1, 0, 16'd17, 16'd9});
        vec_a.push_back('{0, 0, 0, 0, 32'h0, 26'h0, 8'h24, 1, 0, 16'd17, 16'd9});
        // Jump to 0x80 is out of range: fault, nothing retired.
        vec_b.push_back('{0, 1, 0, 0, 32'h0, 26'h20, 8'h00, 0, 1, 16'd0, 16'd0});
        vec_b.push_back('{0, 0, 0, 0, 32'h0, 26'h0, 8'h00, 0, 1, 16'd0, 16'd0});
        // Sequential step from 0x7C reaches 0x80.
        vec_c.push_back('{0, 1, 0, 0, 32'h0, 26'h1F, 8'h7C, 0, 0, 16'd1, 16'd1});
        vec_c.push_back('{0, 0, 0, 0, 32'h0, 26'h0, 8'h7C, 0, 1, 16'd1, 16'd1});
        vec_c.push_back('{1, 0, 0, 0, 32'h0, 26'h0, 8'h7C, 0, 1, 16'd1, 16'd1});

        #2;
        check_all("in_reset", 8'h00, 1'b0, 1'b0, 16'd0, 16'd0);
        do_reset("reset_a");
        foreach (vec_a[i]) apply($sformatf("a%0d", i), vec_a[i]);
        do_reset("reset_b");
        foreach (vec_b[i]) apply($sformatf("b%0d", i), vec_b[i]);
        do_reset("reset_c");
        foreach (vec_c[i]) apply($sformatf("c%0d", i), vec_c[i]);

        // Asynchronous reset between clock edges takes effect without a clock.
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_reset", 8'h00, 1'b0, 1'b0, 16'd0, 16'd0);
        @(posedge clk);
        #1;
        check_all("held_reset", 8'h00, 1'b0, 1'b0, 16'd0, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apply("post_reset", '{0, 0, 0, 0, 32'h0, 26'h0, 8'h04, 0, 0, 16'd1, 16'd0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
